// File: rtl/bclk_bus_master.sv
// bclk_bus_master: MC68040 local-bus initiator for PCI-to-Amiga transfers.
// Ports: BCLK/nRESET clock and reset; REQ_* request handshake (READY pulses on
//   accept); WR_DATA/WR_POP write FIFO head and pop; RD_DATA/RD_PUSH read
//   capture; DONE/ERR status pulses; nBR/nBG/nBB_IN/nBB_OUT/BB_OE arbitration;
//   nTS_OUT/A_OUT/RnW_OUT/SIZ/TT with CTL_OE; D_OUT/D_OE/D_IN data; nTA/nTEA.
module bclk_bus_master #(
    parameter int TA_TIMEOUT = 255,
    parameter int MAX_RETRY  = 3
) (
    input  logic        BCLK,
    input  logic        nRESET,
    input  logic        REQ_VALID,
    input  logic [31:0] REQ_ADDR,
    input  logic        REQ_RnW,
    input  logic        REQ_BURST,
    output logic        REQ_READY,
    input  logic [31:0] WR_DATA,
    output logic        WR_POP,
    output logic [31:0] RD_DATA,
    output logic        RD_PUSH,
    output logic        DONE,
    output logic        ERR,
    output logic        nBR,
    input  logic        nBG,
    input  logic        nBB_IN,
    output logic        nBB_OUT,
    output logic        BB_OE,
    output logic        nTS_OUT,
    output logic        CTL_OE,
    output logic [31:0] A_OUT,
    output logic        RnW_OUT,
    output logic [1:0]  SIZ,
    output logic [1:0]  TT,
    output logic [31:0] D_OUT,
    output logic        D_OE,
    input  logic [31:0] D_IN,
    input  logic        nTA,
    input  logic        nTEA
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_TS,
        S_DATA,
        S_REL
    } state_t;

    localparam logic [7:0] TO_LAST   = 8'(TA_TIMEOUT - 1);
    localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [31:2] addr_q, addr_d;
    logic        rnw_q, rnw_d;
    logic        burst_q, burst_d;
    logic [1:0]  beat_q, beat_d;
    logic [7:0]  to_q, to_d;
    logic [2:0]  retry_q, retry_d;
    logic        again_q, again_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_push_q, rd_push_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic ack_ok;
    logic ack_err;
    logic ack_rty;
    logic last_beat;
    logic unused_addr;

    // Byte lane bits are never driven onto the bus.
    assign unused_addr = ^REQ_ADDR[1:0];

    assign ack_ok    = !nTA && nTEA;
    assign ack_err   = nTA && !nTEA;
    assign ack_rty   = !nTA && !nTEA;
    assign last_beat = burst_q ? (beat_q == 2'd3) : 1'b1;

    always_ff @(posedge BCLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            rnw_q     <= 1'b0;
            burst_q   <= 1'b0;
            beat_q    <= '0;
            to_q      <= '0;
            retry_q   <= '0;
            again_q   <= 1'b0;
            rd_data_q <= '0;
            rd_push_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rnw_q     <= rnw_d;
            burst_q   <= burst_d;
            beat_q    <= beat_d;
            to_q      <= to_d;
            retry_q   <= retry_d;
            again_q   <= again_d;
            rd_data_q <= rd_data_d;
            rd_push_q <= rd_push_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rnw_d     = rnw_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        to_d      = to_q;
        retry_d   = retry_q;
        again_d   = again_q;
        rd_data_d = rd_data_q;
        rd_push_d = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (REQ_VALID) begin
                    addr_d  = REQ_ADDR[31:2];
                    rnw_d   = REQ_RnW;
                    burst_d = REQ_BURST;
                    beat_d  = '0;
                    to_d    = '0;
                    retry_d = '0;
                    again_d = 1'b0;
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (!nBG && nBB_IN) begin
                    state_d = S_TS;
                end
            end
            S_TS: begin
                beat_d  = '0;
                to_d    = '0;
                state_d = S_DATA;
            end
            S_DATA: begin
                if (ack_rty) begin
                    // Retry restarts the whole line; the FIFO still holds it.
                    beat_d  = '0;
                    to_d    = '0;
                    retry_d = retry_q + 3'd1;
                    state_d = S_REL;
                    if (retry_q < RETRY_MAX) begin
                        again_d = 1'b1;
                    end else begin
                        again_d = 1'b0;
                        err_d   = 1'b1;
                    end
                end else if (ack_err) begin
                    again_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_REL;
                end else if (ack_ok) begin
                    to_d   = '0;
                    beat_d = beat_q + 2'd1;
                    if (rnw_q) begin
                        rd_data_d = D_IN;
                        rd_push_d = 1'b1;
                    end
                    if (last_beat) begin
                        again_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_REL;
                    end
                end else if (to_q == TO_LAST) begin
                    again_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_REL;
                end else begin
                    to_d = to_q + 8'd1;
                end
            end
            S_REL: begin
                state_d = again_q ? S_ARB : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Write pop must be combinational so the FIFO head advances on the
    // same edge that takes the beat, ready for a back-to-back TA.
    assign WR_POP    = (state_q == S_DATA) && !rnw_q && ack_ok;
    assign REQ_READY = (state_q == S_IDLE) && REQ_VALID;

    assign RD_DATA = rd_data_q;
    assign RD_PUSH = rd_push_q;
    assign DONE    = done_q;
    assign ERR     = err_q;

    assign nBR     = !(state_q == S_ARB);
    assign BB_OE   = (state_q == S_TS) || (state_q == S_DATA)
                   || (state_q == S_REL);
    assign nBB_OUT = !((state_q == S_TS) || (state_q == S_DATA));
    assign nTS_OUT = !(state_q == S_TS);
    assign CTL_OE  = (state_q == S_TS) || (state_q == S_DATA);
    assign D_OE    = (state_q == S_DATA) && !rnw_q;

    assign A_OUT   = {addr_q, 2'b00};
    assign RnW_OUT = rnw_q;
    assign SIZ     = burst_q ? 2'b11 : 2'b00;
    assign TT      = burst_q ? 2'b01 : 2'b00;
    assign D_OUT   = WR_DATA;

endmodule

// File: tb/tb_bclk_bus_master.sv
// tb_bclk_bus_master: directed scoreboard bench for bclk_bus_master.
// Stimulus pushes expected bus events and probes; a negedge monitor checks.
module tb_bclk_bus_master;

    logic        BCLK;
    logic        nRESET;
    logic        REQ_VALID;
    logic [31:0] REQ_ADDR;
    logic        REQ_RnW;
    logic        REQ_BURST;
    logic        REQ_READY;
    logic [31:0] WR_DATA;
    logic        WR_POP;
    logic [31:0] RD_DATA;
    logic        RD_PUSH;
    logic        DONE;
    logic        ERR;
    logic        nBR;
    logic        nBG;
    logic        nBB_IN;
    logic        nBB_OUT;
    logic        BB_OE;
    logic        nTS_OUT;
    logic        CTL_OE;
    logic [31:0] A_OUT;
    logic        RnW_OUT;
    logic [1:0]  SIZ;
    logic [1:0]  TT;
    logic [31:0] D_OUT;
    logic        D_OE;
    logic [31:0] D_IN;
    logic        nTA;
    logic        nTEA;

    bclk_bus_master dut (
        .BCLK(BCLK), .nRESET(nRESET),
        .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR),
        .REQ_RnW(REQ_RnW), .REQ_BURST(REQ_BURST),
        .REQ_READY(REQ_READY),
        .WR_DATA(WR_DATA), .WR_POP(WR_POP),
        .RD_DATA(RD_DATA), .RD_PUSH(RD_PUSH),
        .DONE(DONE), .ERR(ERR),
        .nBR(nBR), .nBG(nBG), .nBB_IN(nBB_IN),
        .nBB_OUT(nBB_OUT), .BB_OE(BB_OE),
        .nTS_OUT(nTS_OUT), .CTL_OE(CTL_OE),
        .A_OUT(A_OUT), .RnW_OUT(RnW_OUT), .SIZ(SIZ), .TT(TT),
        .D_OUT(D_OUT), .D_OE(D_OE), .D_IN(D_IN),
        .nTA(nTA), .nTEA(nTEA)
    );

    initial BCLK = 1'b0;
    always #5 BCLK = ~BCLK;

    localparam int K_RDY  = 0;
    localparam int K_TS   = 1;
    localparam int K_POP  = 2;
    localparam int K_PUSH = 3;
    localparam int K_DONE = 4;
    localparam int K_ERR  = 5;

    // bus snapshot {nBR,nBB_OUT,BB_OE,nTS_OUT,CTL_OE,D_OE}
    localparam logic [5:0] B_IDLE = 6'b110100;
    localparam logic [5:0] B_ARB  = 6'b010100;
    localparam logic [5:0] B_TS   = 6'b101010;
    localparam logic [5:0] B_DWR  = 6'b101111;
    localparam logic [5:0] B_REL  = 6'b111100;

    typedef struct {
        int          kind;
        logic [31:0] data;
        logic [4:0]  attr;
    } ev_t;

    typedef struct {
        string       name;
        int          kind;
        logic [63:0] got;
        logic [63:0] exp;
        logic [63:0] mask;
    } probe_t;

    ev_t    sq[$];
    probe_t pq[$];

    int total = 0;
    int bad   = 0;

    // write FIFO model
    logic [31:0] wdata [8];
    int          head;
    logic        fifo_clr;

    always @(posedge BCLK) begin
        if (fifo_clr) head <= 0;
        else if (WR_POP) head <= head + 1;
    end
    assign WR_DATA = wdata[head[2:0]];

    function automatic string kname(input int k);
        case (k)
            K_RDY:   return "ready";
            K_TS:    return "ts";
            K_POP:   return "wr_pop";
            K_PUSH:  return "rd_push";
            K_DONE:  return "done";
            K_ERR:   return "err";
            default: return "unknown";
        endcase
    endfunction

    task automatic sb_check(input int k, input logic [31:0] d,
                            input logic [4:0] at);
        ev_t e;
        total++;
        if (sq.size() == 0) begin
            bad++;
            $display("FAIL sb_%s: unexpected event data=%h attr=%b",
                     kname(k), d, at);
        end else begin
            e = sq.pop_front();
            if (e.kind != k || e.data !== d || e.attr !== at) begin
                bad++;
                $display("FAIL sb_%s: got %s data=%h attr=%b want %s data=%h attr=%b",
                         kname(k), kname(k), d, at,
                         kname(e.kind), e.data, e.attr);
            end
        end
    endtask

    probe_t      mp;
    logic [63:0] mg;

    always @(negedge BCLK) begin
        while (pq.size() > 0) begin
            mp = pq.pop_front();
            case (mp.kind)
                0:       mg = {26'd0, nBR, nBB_OUT, BB_OE, nTS_OUT,
                               CTL_OE, D_OE, RD_DATA};
                2:       mg = 64'(sq.size());
                default: mg = mp.got;
            endcase
            total++;
            if ((mg & mp.mask) !== (mp.exp & mp.mask)) begin
                bad++;
                $display("FAIL %s: got %h want %h", mp.name,
                         mg & mp.mask, mp.exp & mp.mask);
            end
        end
        if (nRESET) begin
            if (REQ_READY) sb_check(K_RDY, 32'd0, 5'd0);
            if (!nTS_OUT) sb_check(K_TS, A_OUT, {RnW_OUT, SIZ, TT});
            if (WR_POP) sb_check(K_POP, D_OUT, 5'd0);
            if (RD_PUSH) sb_check(K_PUSH, RD_DATA, 5'd0);
            if (DONE) sb_check(K_DONE, 32'd0, 5'd0);
            if (ERR) sb_check(K_ERR, 32'd0, 5'd0);
        end
    end

    task automatic expect_ev(input int k, input logic [31:0] d,
                             input logic [4:0] at);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.attr = at;
        sq.push_back(e);
    endtask

    task automatic probe_bus(input string n, input logic [5:0] b);
        probe_t p;
        p.name = n;
        p.kind = 0;
        p.got  = '0;
        p.exp  = {26'd0, b, 32'd0};
        p.mask = {26'd0, 6'h3f, 32'd0};
        pq.push_back(p);
    endtask

    task automatic probe_rd(input string n, input logic [5:0] b,
                            input logic [31:0] rd);
        probe_t p;
        p.name = n;
        p.kind = 0;
        p.got  = '0;
        p.exp  = {26'd0, b, rd};
        p.mask = {26'd0, 6'h3f, 32'hffff_ffff};
        pq.push_back(p);
    endtask

    task automatic probe_val(input string n, input int g, input int x);
        probe_t p;
        p.name = n;
        p.kind = 1;
        p.got  = 64'(g);
        p.exp  = 64'(x);
        p.mask = '1;
        pq.push_back(p);
    endtask

    task automatic probe_drained();
        probe_t p;
        p.name = "sb_drained";
        p.kind = 2;
        p.got  = '0;
        p.exp  = '0;
        p.mask = '1;
        pq.push_back(p);
    endtask

    task automatic tick();
        @(posedge BCLK);
        #1;
    endtask

    task automatic submit(input logic [31:0] a, input logic rnw,
                          input logic burst);
        logic acc;
        acc       = 1'b0;
        REQ_ADDR  = a;
        REQ_RnW   = rnw;
        REQ_BURST = burst;
        REQ_VALID = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge BCLK);
            acc = REQ_READY;
            tick();
        end
        REQ_VALID = 1'b0;
        if (!acc) probe_val("req_ready_wait", 0, 1);
    endtask

    task automatic wait_ts();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (!nTS_OUT) seen = 1'b1;
            else tick();
        end
        if (!seen) probe_val("ts_wait", 0, 1);
    endtask

    task automatic ack(input int gap, input logic ta, input logic tea,
                       input logic [31:0] d);
        repeat (gap) tick();
        nTA  = !ta;
        nTEA = !tea;
        D_IN = d;
        tick();
        nTA  = 1'b1;
        nTEA = 1'b1;
    endtask

    task automatic load_fifo(input logic [31:0] base);
        for (int i = 0; i < 8; i++) wdata[i] = base + 32'(i);
        fifo_clr = 1'b1;
        tick();
        fifo_clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        nRESET    = 1'b0;
        REQ_VALID = 1'b0;
        REQ_ADDR  = '0;
        REQ_RnW   = 1'b0;
        REQ_BURST = 1'b0;
        nBG       = 1'b1;
        nBB_IN    = 1'b1;
        nTA       = 1'b1;
        nTEA      = 1'b1;
        D_IN      = '0;
        fifo_clr  = 1'b1;
        for (int i = 0; i < 8; i++) wdata[i] = '0;
        repeat (3) tick();
        nRESET = 1'b1;
        fifo_clr = 1'b0;
        tick();
        probe_rd("reset_state", B_IDLE, 32'd0);
        nBG = 1'b0;

        // single write, TA two clocks after TS
        load_fifo(32'hCAFE_BABE);
        expect_ev(K_RDY, 32'd0, 5'd0);
        expect_ev(K_TS, 32'h0040_0010, 5'b0_00_00);
        expect_ev(K_POP, 32'hCAFE_BABE, 5'd0);
        expect_ev(K_DONE, 32'd0, 5'd0);
        submit(32'h0040_0010, 1'b0, 1'b0);
        wait_ts();
        tick();
        probe_bus("wr1_data_c1", B_DWR);
        tick();
        probe_bus("wr1_data_c2", B_DWR);
        nTA = 1'b0;
        tick();
        nTA = 1'b1;
        probe_bus("wr1_rel", B_REL);
        tick();
        probe_rd("wr1_idle", B_IDLE, 32'd0);

        // line read, TA every clock
        expect_ev(K_RDY, 32'd0, 5'd0);
        expect_ev(K_TS, 32'h0020_0000, 5'b1_11_01);
        for (int i = 1; i <= 4; i++)
            expect_ev(K_PUSH, 32'h11 * 32'(i), 5'd0);
        expect_ev(K_DONE, 32'd0, 5'd0);
        submit(32'h0020_0000, 1'b1, 1'b1);
        wait_ts();
        for (int i = 1; i <= 4; i++)
            ack(i == 1 ? 1 : 0, 1'b1, 1'b0, 32'h11 * 32'(i));
        probe_bus("rd_line_rel", B_REL);
        tick();
        probe_rd("rd_line_idle", B_IDLE, 32'h44);

        // bus busy for 5 clocks, addr low bits ignored
        nBB_IN = 1'b0;
        expect_ev(K_RDY, 32'd0, 5'd0);
        expect_ev(K_TS, 32'h0000_0100, 5'b1_00_00);
        expect_ev(K_PUSH, 32'h5A5A_0001, 5'd0);
        expect_ev(K_DONE, 32'd0, 5'd0);
        submit(32'h0000_0103, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            probe_bus("arb_bb_busy", B_ARB);
            tick();
        end
        nBB_IN = 1'b1;
        tick();
        probe_bus("arb_ts_first_edge", B_TS);
        ack(1, 1'b1, 1'b0, 32'h5A5A_0001);
        tick();
        probe_rd("bb_idle", B_IDLE, 32'h5A5A_0001);

        // line write, TEA on beat 2
        load_fifo(32'hA000_0000);
        expect_ev(K_RDY, 32'd0, 5'd0);
        expect_ev(K_TS, 32'h0030_0000, 5'b0_11_01);
        expect_ev(K_POP, 32'hA000_0000, 5'd0);
        expect_ev(K_POP, 32'hA000_0001, 5'd0);
        expect_ev(K_ERR, 32'd0, 5'd0);
        submit(32'h0030_0000, 1'b0, 1'b1);
        wait_ts();
        ack(1, 1'b1, 1'b0, 32'd0);
        ack(0, 1'b1, 1'b0, 32'd0);
        ack(0, 1'b0, 1'b1, 32'd0);
        probe_bus("tea_rel", B_REL);
        tick();
        probe_bus("tea_idle", B_IDLE);

        // retry on beat 1 until exhausted
        expect_ev(K_RDY, 32'd0, 5'd0);
        for (int k = 0; k < 4; k++) begin
            expect_ev(K_TS, 32'h0050_0000, 5'b1_11_01);
            expect_ev(K_PUSH, 32'hB0 + 32'(k), 5'd0);
        end
        expect_ev(K_ERR, 32'd0, 5'd0);
        submit(32'h0050_0000, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            wait_ts();
            ack(1, 1'b1, 1'b0, 32'hB0 + 32'(k));
            ack(0, 1'b1, 1'b1, 32'hDEAD);
            if (k < 3) begin
                tick();
                probe_bus("retry_rearb", B_ARB);
            end
        end
        probe_bus("retry_err_rel", B_REL);
        tick();
        probe_rd("retry_err_idle", B_IDLE, 32'hB3);

        // one retry then a full line: restart at beat 0
        expect_ev(K_RDY, 32'd0, 5'd0);
        expect_ev(K_TS, 32'h0060_0000, 5'b1_11_01);
        expect_ev(K_PUSH, 32'hC0, 5'd0);
        expect_ev(K_TS, 32'h0060_0000, 5'b1_11_01);
        for (int i = 1; i <= 4; i++)
            expect_ev(K_PUSH, 32'hC0 + 32'(i), 5'd0);
        expect_ev(K_DONE, 32'd0, 5'd0);
        submit(32'h0060_0000, 1'b1, 1'b1);
        wait_ts();
        ack(1, 1'b1, 1'b0, 32'hC0);
        ack(0, 1'b1, 1'b1, 32'hDEAD);
        tick();
        wait_ts();
        for (int i = 1; i <= 4; i++)
            ack(i == 1 ? 1 : 0, 1'b1, 1'b0, 32'hC0 + 32'(i));
        tick();
        probe_rd("retry_ok_idle", B_IDLE, 32'hC4);

        // no TA: timeout
        expect_ev(K_RDY, 32'd0, 5'd0);
        expect_ev(K_TS, 32'h0000_0200, 5'b1_00_00);
        expect_ev(K_ERR, 32'd0, 5'd0);
        submit(32'h0000_0200, 1'b1, 1'b0);
        wait_ts();
        n = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            n++;
            if (ERR) break;
        end
        probe_val("timeout_ts_to_err", n, 256);
        tick();
        probe_bus("timeout_idle", B_IDLE);

        // reset mid-burst
        load_fifo(32'hD000_0000);
        expect_ev(K_RDY, 32'd0, 5'd0);
        expect_ev(K_TS, 32'h0010_0000, 5'b0_11_01);
        expect_ev(K_POP, 32'hD000_0000, 5'd0);
        submit(32'h0010_0000, 1'b0, 1'b1);
        wait_ts();
        ack(1, 1'b1, 1'b0, 32'd0);
        probe_bus("mid_burst_data", B_DWR);
        tick();
        nRESET = 1'b0;
        probe_rd("reset_mid_burst", B_IDLE, 32'd0);
        repeat (2) tick();
        nRESET = 1'b1;
        tick();
        probe_bus("after_reset_idle", B_IDLE);
        probe_drained();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
